// File: rtl/smash_pkg.sv
// smash_pkg
//   Shared definitions for the smash port arbiter.
//   - Default parameter values for the number of source ports and the flit width.
//   - TAIL_BIT: index of the end-of-packet flag in a default-width flit.
//   - arb_state_t: arbiter FSM state encoding.
//   - Helpers that derive the grant-index width and tail-bit index from the parameters.
package smash_pkg;

  localparam int DEFAULT_NUM_PORTS = 4;
  localparam int DEFAULT_DATA_SIZE = 32;
  localparam int TAIL_BIT          = DEFAULT_DATA_SIZE - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  // Width needed to hold a port index. A single-port build still needs one bit.
  function automatic int idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  // The tail flag is always the most significant bit of a flit.
  function automatic int tail_index(input int data_size);
    return data_size - 1;
  endfunction

endpackage

// File: rtl/smash_rr_arbiter.sv
// smash_rr_arbiter
//   Combinational rotating-priority search. The search starts at the port
//   after last_grant and wraps around, so the port served most recently gets
//   the lowest priority.
// Ports:
//   req        - request vector, one bit per port
//   last_grant - index of the most recently served port
//   grant      - one-hot winner; all zero when nothing is requested
//   valid      - high when some port is requesting
module smash_rr_arbiter
  import smash_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [NUM_PORTS-1:0] grant,
  output logic                 valid
);

  logic found;

  // Two ascending passes model the wrap-around without any modulo arithmetic.
  // The first pass looks only above last_grant. The second pass wraps back to
  // port 0 and covers the rest, including last_grant itself.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i] && (i > int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && req[i] && (i <= int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/smash_port_arbiter.sv
// smash_port_arbiter
//   Moves whole packets from NUM_PORTS source FIFOs into one destination FIFO.
//   Once a port wins, it keeps the link until its tail flit has been written.
//   Each flit takes a READ cycle (pop the source) followed by a WRITE cycle
//   (push the destination).
// Ports:
//   i_clk, i_rst  - clock; synchronous active-high reset
//   i_src_empty   - empty flag of each source FIFO
//   i_src_data    - read data of each source FIFO; port p is slice p
//   o_src_read    - one-cycle pop to the granted source FIFO
//   i_dst_full    - full flag of the destination FIFO
//   o_dst_write   - push to the destination FIFO
//   o_dst_data    - flit pushed to the destination FIFO (zero when not writing)
//   o_grant       - one-hot owner of the link; zero when idle
//   o_busy        - high while a packet holds the link
module smash_port_arbiter
  import smash_pkg::*;
#(
  parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [NUM_PORTS-1:0]           i_src_empty,
  input  logic [NUM_PORTS*DATA_SIZE-1:0] i_src_data,
  output logic [NUM_PORTS-1:0]           o_src_read,
  input  logic                           i_dst_full,
  output logic                           o_dst_write,
  output logic [DATA_SIZE-1:0]           o_dst_data,
  output logic [NUM_PORTS-1:0]           o_grant,
  output logic                           o_busy
);

  localparam int IDX_W = idx_width(NUM_PORTS);
  localparam int TAIL  = tail_index(DATA_SIZE);

  arb_state_t           state, state_next;
  logic [IDX_W-1:0]     grant, last_grant, arb_idx;
  logic [NUM_PORTS-1:0] arb_onehot, grant_onehot;
  logic                 arb_valid;
  logic [DATA_SIZE-1:0] granted_flit;
  logic                 flit_is_tail;
  logic                 can_move;

  smash_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr (
    .req        (~i_src_empty),
    .last_grant (last_grant),
    .grant      (arb_onehot),
    .valid      (arb_valid)
  );

  // Turn the arbiter's one-hot winner into an index so it can be stored in the grant register.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_onehot[i]) begin
        arb_idx = IDX_W'(i);
      end
    end
  end

  assign grant_onehot = NUM_PORTS'(1) << grant;
  assign granted_flit = i_src_data[int'(grant)*DATA_SIZE +: DATA_SIZE];
  assign flit_is_tail = granted_flit[TAIL];
  assign can_move     = !i_src_empty[grant] && !i_dst_full;

  // Next-state logic. All outputs are decoded from the state alone.
  // The only exception is o_dst_data, which passes the granted flit straight
  // through so the write happens in the cycle right after the read.
  always_comb begin
    state_next  = state;
    o_src_read  = '0;
    o_dst_write = 1'b0;
    o_dst_data  = '0;
    o_grant     = '0;
    o_busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (arb_valid && !i_dst_full) begin
          state_next = READ;
        end
      end
      READ: begin
        o_src_read = grant_onehot;
        o_grant    = grant_onehot;
        o_busy     = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        o_dst_write = 1'b1;
        o_dst_data  = granted_flit;
        o_grant     = grant_onehot;
        o_busy      = 1'b1;
        if (flit_is_tail) begin
          state_next = IDLE;
        end else if (can_move) begin
          state_next = READ;
        end else begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        o_grant = grant_onehot;
        o_busy  = 1'b1;
        if (can_move) begin
          state_next = READ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The grant is captured only when leaving IDLE. This locks the link to one
  // port for the whole packet. last_grant moves only when a packet completes,
  // so a packet cut short by reset does not rotate the priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == READ) begin
        grant <= arb_idx;
      end
      if (state == WRITE && flit_is_tail) begin
        last_grant <= grant;
      end
    end
  end

endmodule

// File: tb/tb_smash_port_arbiter.sv
// tb_smash_port_arbiter
//   Directed cycle-by-cycle vectors for the four-port, 32-bit arbiter.
//   Each vector supplies the inputs for one clock cycle and the outputs
//   expected in that same cycle. Inputs change on the falling edge and are
//   checked shortly after it.
module tb_smash_port_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   src_empty;
  logic [127:0] src_data;
  logic [3:0]   src_read;
  logic         dst_full;
  logic         dst_write;
  logic [31:0]  dst_data;
  logic [3:0]   grant;
  logic         busy;

  int checks;
  int failures;

  typedef struct {
    logic         rst;
    logic [3:0]   empty;
    logic         full;
    logic [127:0] data;
    logic [3:0]   exp_read;
    logic         exp_write;
    logic [31:0]  exp_data;
    logic [3:0]   exp_grant;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  smash_port_arbiter #(
    .NUM_PORTS (4),
    .DATA_SIZE (32)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_src_empty (src_empty),
    .i_src_data  (src_data),
    .o_src_read  (src_read),
    .i_dst_full  (dst_full),
    .o_dst_write (dst_write),
    .o_dst_data  (dst_data),
    .o_grant     (grant),
    .o_busy      (busy)
  );

  // Free-running clock with a 10-time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] pk(input logic [31:0] d3, input logic [31:0] d2,
                                      input logic [31:0] d1, input logic [31:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(input logic r, input logic [3:0] e, input logic f,
                              input logic [127:0] d, input logic [3:0] er, input logic ew,
                              input logic [31:0] ed, input logic [3:0] eg, input logic eb);
    vec_t v;
    v.rst = r; v.empty = e; v.full = f; v.data = d;
    v.exp_read = er; v.exp_write = ew; v.exp_data = ed; v.exp_grant = eg; v.exp_busy = eb;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] e, input logic f,
                               input logic [127:0] d);
    @(negedge clk);
    rst       = r;
    src_empty = e;
    dst_full  = f;
    src_data  = d;
  endtask

  task automatic checkField(input string tag, input int idx, input string field,
                            input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s[%0d] %s got %h want %h", tag, idx, field, got, want);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic [3:0] er,
                             input logic ew, input logic [31:0] ed, input logic [3:0] eg,
                             input logic eb);
    #1;
    checkField(tag, idx, "src_read",  32'(src_read),  32'(er));
    checkField(tag, idx, "dst_write", 32'(dst_write), 32'(ew));
    checkField(tag, idx, "dst_data",  dst_data,       ed);
    checkField(tag, idx, "grant",     32'(grant),     32'(eg));
    checkField(tag, idx, "busy",      32'(busy),      32'(eb));
  endtask

  task automatic step(input string tag, input int idx, input logic r, input logic [3:0] e,
                      input logic f, input logic [127:0] d, input logic [3:0] er,
                      input logic ew, input logic [31:0] ed, input logic [3:0] eg,
                      input logic eb);
    applyStimulus(r, e, f, d);
    checkOutput(tag, idx, er, ew, ed, eg, eb);
  endtask

  initial begin
    logic [127:0] da, db0, db1, db2, db3, dd0, dd1, dd2, dc, de;
    checks   = 0;
    failures = 0;

    rst       = 1'b1;
    src_empty = 4'b1111;
    dst_full  = 1'b0;
    src_data  = '0;
    repeat (2) @(posedge clk);

    // Reset, then four single-flit tail packets served in the order 0, 1, 2, 3.
    da = pk(32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000);
    vecs.push_back(mk(1, 4'b1111, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b0000, 0, da, 4'b0001, 0, 32'h0,         4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, da, 4'b0000, 1, 32'hC000_0000, 4'b0001, 1));
    vecs.push_back(mk(0, 4'b0001, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b0001, 0, da, 4'b0010, 0, 32'h0,         4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, da, 4'b0000, 1, 32'hC000_0001, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b0011, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b0011, 0, da, 4'b0100, 0, 32'h0,         4'b0100, 1));
    vecs.push_back(mk(0, 4'b0111, 0, da, 4'b0000, 1, 32'hC000_0002, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b0111, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b0111, 0, da, 4'b1000, 0, 32'h0,         4'b1000, 1));
    vecs.push_back(mk(0, 4'b1111, 0, da, 4'b0000, 1, 32'hC000_0003, 4'b1000, 1));
    vecs.push_back(mk(0, 4'b1111, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b1111, 0, da, 4'b0000, 0, 32'h0,         4'b0000, 0));

    // Three-flit packet on port 1 goes out whole before port 2's packet.
    db0 = pk(32'h0, 32'h8000_0044, 32'h0,         32'h0);
    db1 = pk(32'h0, 32'h8000_0044, 32'h0000_0011, 32'h0);
    db2 = pk(32'h0, 32'h8000_0044, 32'h0000_0022, 32'h0);
    db3 = pk(32'h0, 32'h8000_0044, 32'h8000_0033, 32'h0);
    vecs.push_back(mk(0, 4'b1001, 0, db0, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b1001, 0, db0, 4'b0010, 0, 32'h0,         4'b0010, 1));
    vecs.push_back(mk(0, 4'b1001, 0, db1, 4'b0000, 1, 32'h0000_0011, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b1001, 0, db1, 4'b0010, 0, 32'h0,         4'b0010, 1));
    vecs.push_back(mk(0, 4'b1001, 0, db2, 4'b0000, 1, 32'h0000_0022, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b1001, 0, db2, 4'b0010, 0, 32'h0,         4'b0010, 1));
    vecs.push_back(mk(0, 4'b1011, 0, db3, 4'b0000, 1, 32'h8000_0033, 4'b0010, 1));
    vecs.push_back(mk(0, 4'b1011, 0, db3, 4'b0000, 0, 32'h0,         4'b0000, 0));
    vecs.push_back(mk(0, 4'b1011, 0, db3, 4'b0100, 0, 32'h0,         4'b0100, 1));
    vecs.push_back(mk(0, 4'b1111, 0, db3, 4'b0000, 1, 32'h8000_0044, 4'b0100, 1));
    vecs.push_back(mk(0, 4'b1111, 0, db3, 4'b0000, 0, 32'h0,         4'b0000, 0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].empty, vecs[i].full, vecs[i].data);
      checkOutput("table", i, vecs[i].exp_read, vecs[i].exp_write, vecs[i].exp_data,
                  vecs[i].exp_grant, vecs[i].exp_busy);
    end

    // Port 0 stalls mid-packet: the link holds on port 0 while port 3 waits.
    dd0 = pk(32'h8000_0077, 32'h0, 32'h0, 32'h0);
    dd1 = pk(32'h8000_0077, 32'h0, 32'h0, 32'h0000_AAAA);
    dd2 = pk(32'h8000_0077, 32'h0, 32'h0, 32'h8000_BBBB);
    step("hold", 0,  1, 4'b0110, 0, dd0, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("hold", 1,  0, 4'b0110, 0, dd0, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("hold", 2,  0, 4'b0110, 0, dd0, 4'b0001, 0, 32'h0,         4'b0001, 1);
    step("hold", 3,  0, 4'b0111, 0, dd1, 4'b0000, 1, 32'h0000_AAAA, 4'b0001, 1);
    step("hold", 4,  0, 4'b0111, 0, dd1, 4'b0000, 0, 32'h0,         4'b0001, 1);
    step("hold", 5,  0, 4'b0111, 0, dd1, 4'b0000, 0, 32'h0,         4'b0001, 1);
    step("hold", 6,  0, 4'b0110, 0, dd1, 4'b0000, 0, 32'h0,         4'b0001, 1);
    step("hold", 7,  0, 4'b0110, 0, dd1, 4'b0001, 0, 32'h0,         4'b0001, 1);
    step("hold", 8,  0, 4'b0111, 0, dd2, 4'b0000, 1, 32'h8000_BBBB, 4'b0001, 1);
    step("hold", 9,  0, 4'b0111, 0, dd2, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("hold", 10, 0, 4'b0111, 0, dd2, 4'b1000, 0, 32'h0,         4'b1000, 1);
    step("hold", 11, 0, 4'b1111, 0, dd2, 4'b0000, 1, 32'h8000_0077, 4'b1000, 1);
    step("hold", 12, 0, 4'b1111, 0, dd2, 4'b0000, 0, 32'h0,         4'b0000, 0);

    // Destination full while idle: nothing is read until full drops.
    dc = pk(32'h0, 32'h0, 32'h0, 32'h8000_0055);
    step("full", 0, 0, 4'b1110, 1, dc, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("full", 1, 0, 4'b1110, 1, dc, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("full", 2, 0, 4'b1110, 0, dc, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("full", 3, 0, 4'b1110, 0, dc, 4'b0001, 0, 32'h0,         4'b0001, 1);
    step("full", 4, 0, 4'b1111, 0, dc, 4'b0000, 1, 32'h8000_0055, 4'b0001, 1);
    step("full", 5, 0, 4'b1111, 0, dc, 4'b0000, 0, 32'h0,         4'b0000, 0);

    // Reset while holding mid-packet on port 1: the packet is dropped and port 0 wins next.
    de = pk(32'h0, 32'h0, 32'h0000_0099, 32'h8000_00AA);
    step("rst", 0, 0, 4'b1101, 0, de, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("rst", 1, 0, 4'b1101, 0, de, 4'b0010, 0, 32'h0,         4'b0010, 1);
    step("rst", 2, 0, 4'b1111, 0, de, 4'b0000, 1, 32'h0000_0099, 4'b0010, 1);
    step("rst", 3, 0, 4'b1111, 0, de, 4'b0000, 0, 32'h0,         4'b0010, 1);
    step("rst", 4, 1, 4'b1111, 0, de, 4'b0000, 0, 32'h0,         4'b0010, 1);
    step("rst", 5, 0, 4'b1100, 0, de, 4'b0000, 0, 32'h0,         4'b0000, 0);
    step("rst", 6, 0, 4'b1100, 0, de, 4'b0001, 0, 32'h0,         4'b0001, 1);
    step("rst", 7, 0, 4'b1101, 0, de, 4'b0000, 1, 32'h8000_00AA, 4'b0001, 1);
    step("rst", 8, 0, 4'b1101, 0, de, 4'b0000, 0, 32'h0,         4'b0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
